// File: rtl/ex_multicycle_ctrl_pkg.sv
// Shared encodings for the EX-stage multi-cycle HI/LO sequencer:
// opcodes, FSM states, stall/reset constants and the HI/LO bus width.
package ex_multicycle_ctrl_pkg;

  localparam int DOUBLE_REG_W = 64;

  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic RESET_ENABLE = 1'b1;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MADD  = 3'd1,
    OP_MADDU = 3'd2,
    OP_MSUB  = 3'd3,
    OP_MSUBU = 3'd4,
    OP_DIV   = 3'd5,
    OP_DIVU  = 3'd6
  } mc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC_ACC,
    ST_DIV_WAIT,
    ST_DONE
  } mc_state_e;

  function automatic logic is_mac(input logic [2:0] op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_sub(input logic [2:0] op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/ex_multicycle_ctrl.sv
// EX-stage sequencer for two-cycle multiply-accumulate and the
// start/ready/annul handshake with the iterative divider.
module ex_multicycle_ctrl
  import ex_multicycle_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            op,
  input  logic                  op_valid,
  input  logic                  flush,
  input  logic [5:0]            stall,
  input  logic [2*DATA_W-1:0]   mul_result,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic [2*DATA_W-1:0]   div_result,
  input  logic                  div_ready,
  output logic                  div_start,
  output logic                  div_signed,
  output logic                  div_annul,
  output logic [DATA_W-1:0]     div_op1,
  output logic [DATA_W-1:0]     div_op2,
  output logic                  stallreq,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic                  hilo_valid
);

  mc_state_e state, state_n;

  logic [2*DATA_W-1:0] prod_r;
  logic [2*DATA_W-1:0] res_r;
  logic [2*DATA_W-1:0] mac_val;
  logic [DATA_W-1:0]   div_op1_r;
  logic [DATA_W-1:0]   div_op2_r;
  logic                sub_r;
  logic                div_start_r;
  logic                div_signed_r;
  logic                ld_mac;
  logic                ld_div;
  logic                ld_zero;
  logic                ld_res;
  logic                unused_stall;

  // Only the EX hold bit matters here.
  assign unused_stall = ^{stall[5:4], stall[2:0]};

  assign mac_val = sub_r ? hilo_i - prod_r : hilo_i + prod_r;

  always_comb begin
    state_n    = state;
    stallreq   = 1'b0;
    hilo_valid = 1'b0;
    hilo_o     = '0;
    div_annul  = 1'b0;
    ld_mac     = 1'b0;
    ld_div     = 1'b0;
    ld_zero    = 1'b0;
    ld_res     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (op_valid && is_mac(op)) begin
          stallreq = 1'b1;
          ld_mac   = 1'b1;
          state_n  = ST_MAC_ACC;
        end else if (op_valid && is_div(op)) begin
          stallreq = 1'b1;
          if (opdata2 != '0) begin
            ld_div  = 1'b1;
            state_n = ST_DIV_WAIT;
          end else begin
            ld_zero = 1'b1;
            state_n = ST_DONE;
          end
        end
      end
      ST_MAC_ACC: begin
        hilo_o     = mac_val;
        hilo_valid = 1'b1;
        if (stall[3] == NO_STOP) state_n = ST_IDLE;
      end
      ST_DIV_WAIT: begin
        stallreq = 1'b1;
        if (div_ready) begin
          ld_res  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        hilo_o     = res_r;
        hilo_valid = 1'b1;
        if (stall[3] == NO_STOP) state_n = ST_IDLE;
      end
    endcase
    // An exception kills whatever is in flight, including a same-cycle result.
    if (flush) begin
      state_n    = ST_IDLE;
      stallreq   = 1'b0;
      hilo_valid = 1'b0;
      hilo_o     = '0;
      div_annul  = (state == ST_DIV_WAIT);
      ld_mac     = 1'b0;
      ld_div     = 1'b0;
      ld_zero    = 1'b0;
      ld_res     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RESET_ENABLE) begin
      state        <= ST_IDLE;
      prod_r       <= '0;
      res_r        <= '0;
      sub_r        <= 1'b0;
      div_op1_r    <= '0;
      div_op2_r    <= '0;
      div_signed_r <= 1'b0;
      div_start_r  <= 1'b0;
    end else begin
      state       <= state_n;
      div_start_r <= (state_n == ST_DIV_WAIT);
      if (flush) begin
        prod_r <= '0;
        res_r  <= '0;
      end else begin
        if (ld_mac) begin
          prod_r <= mul_result;
          sub_r  <= is_sub(op);
        end
        if (ld_div) begin
          div_op1_r    <= opdata1;
          div_op2_r    <= opdata2;
          div_signed_r <= (op == OP_DIV);
        end
        if (ld_zero) res_r <= '0;
        if (ld_res)  res_r <= div_result;
      end
    end
  end

  assign div_start  = div_start_r;
  assign div_signed = div_signed_r;
  assign div_op1    = div_op1_r;
  assign div_op2    = div_op2_r;

endmodule

// File: tb/tb_ex_multicycle_ctrl.sv
// Randomized self-checking bench for ex_multicycle_ctrl with a
// behavioural divider and HI/LO arithmetic reference.
module tb_ex_multicycle_ctrl;
  import ex_multicycle_ctrl_pkg::*;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [2:0]     op;
  logic           op_valid;
  logic           flush;
  logic [5:0]     stall;
  logic [5:0]     stall_ext;
  logic [2*W-1:0] mul_result;
  logic [2*W-1:0] hilo_i;
  logic [W-1:0]   opdata1;
  logic [W-1:0]   opdata2;
  logic [2*W-1:0] div_result;
  logic           div_ready;
  logic           div_start;
  logic           div_signed;
  logic           div_annul;
  logic [W-1:0]   div_op1;
  logic [W-1:0]   div_op2;
  logic           stallreq;
  logic [2*W-1:0] hilo_o;
  logic           hilo_valid;

  int vectors = 0;
  int miscompares = 0;
  int unsigned div_lat = 34;
  int unsigned div_cnt;

  ex_multicycle_ctrl #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .op(op), .op_valid(op_valid), .flush(flush),
    .stall(stall), .mul_result(mul_result), .hilo_i(hilo_i),
    .opdata1(opdata1), .opdata2(opdata2), .div_result(div_result),
    .div_ready(div_ready), .div_start(div_start), .div_signed(div_signed),
    .div_annul(div_annul), .div_op1(div_op1), .div_op2(div_op2),
    .stallreq(stallreq), .hilo_o(hilo_o), .hilo_valid(hilo_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stall controller: EX request holds IF..EX; bench may add MEM stalls.
  assign stall = stall_ext | (stallreq ? 6'b001111 : 6'b000000);

  function automatic logic [2*W-1:0] div_calc(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider: ready pulse after div_lat cycles of sampled start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= 0;
      div_ready  <= 1'b0;
      div_result <= '0;
    end else begin
      div_ready <= 1'b0;
      if (!div_start || div_annul || div_ready) begin
        div_cnt <= 0;
      end else if (div_cnt + 1 == div_lat) begin
        div_ready  <= 1'b1;
        div_result <= div_calc(div_signed, div_op1, div_op2);
        div_cnt    <= 0;
      end else begin
        div_cnt <= div_cnt + 1;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = OP_NOP; op_valid = 1'b0; flush = 1'b0; stall_ext = '0;
    mul_result = '0; hilo_i = '0; opdata1 = '0; opdata2 = '0;
    @(posedge clk); @(posedge clk); #2;
    vectors++; if (stallreq !== 1'b0) begin miscompares++; $display("FAIL rst_stallreq: got %b want 0", stallreq); end
    vectors++; if (hilo_valid !== 1'b0) begin miscompares++; $display("FAIL rst_hilo_valid: got %b want 0", hilo_valid); end
    vectors++; if (hilo_o !== 64'h0) begin miscompares++; $display("FAIL rst_hilo_o: got %h want 0", hilo_o); end
    vectors++; if (div_start !== 1'b0) begin miscompares++; $display("FAIL rst_div_start: got %b want 0", div_start); end
    vectors++; if (div_annul !== 1'b0) begin miscompares++; $display("FAIL rst_div_annul: got %b want 0", div_annul); end
    vectors++; if ({div_signed, div_op1, div_op2} !== 65'h0) begin miscompares++; $display("FAIL rst_div_regs: got %h want 0", {div_signed, div_op1, div_op2}); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic run_mac(input logic [2:0] o, input logic [63:0] h0, input logic [63:0] m, input logic [63:0] h1, input string nm);
    logic [63:0] exp;
    next_cycle();
    op = o; op_valid = 1'b1; hilo_i = h0; mul_result = m;
    #1;
    vectors++; if (stallreq !== 1'b1) begin miscompares++; $display("FAIL %s_issue_stallreq: got %b want 1", nm, stallreq); end
    vectors++; if (hilo_valid !== 1'b0) begin miscompares++; $display("FAIL %s_issue_valid: got %b want 0", nm, hilo_valid); end
    next_cycle();
    op = OP_NOP; op_valid = 1'b0; hilo_i = h1; mul_result = {$urandom, $urandom};
    #1;
    exp = (o == OP_MSUB || o == OP_MSUBU) ? h1 - m : h1 + m;
    vectors++; if (hilo_valid !== 1'b1) begin miscompares++; $display("FAIL %s_valid: got %b want 1", nm, hilo_valid); end
    vectors++; if (hilo_o !== exp) begin miscompares++; $display("FAIL %s_hilo: got %h want %h", nm, hilo_o, exp); end
    vectors++; if (stallreq !== 1'b0) begin miscompares++; $display("FAIL %s_stallreq: got %b want 0", nm, stallreq); end
    next_cycle();
    #1;
    vectors++; if (hilo_valid !== 1'b0) begin miscompares++; $display("FAIL %s_after: got %b want 0", nm, hilo_valid); end
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input int unsigned lat, input string nm);
    logic [63:0] exp;
    int stalls;
    int guard;
    div_lat = lat;
    exp = (b == 0) ? 64'h0 : div_calc(s, a, b);
    next_cycle();
    op = s ? OP_DIV : OP_DIVU; op_valid = 1'b1; opdata1 = a; opdata2 = b;
    #1;
    vectors++; if (stallreq !== 1'b1) begin miscompares++; $display("FAIL %s_issue_stallreq: got %b want 1", nm, stallreq); end
    vectors++; if (div_start !== 1'b0) begin miscompares++; $display("FAIL %s_issue_start: got %b want 0", nm, div_start); end
    next_cycle();
    op = OP_NOP; op_valid = 1'b0; opdata1 = $urandom; opdata2 = $urandom;
    #1;
    if (b == 0) begin
      vectors++; if (hilo_valid !== 1'b1) begin miscompares++; $display("FAIL %s_valid: got %b want 1", nm, hilo_valid); end
      vectors++; if (hilo_o !== 64'h0) begin miscompares++; $display("FAIL %s_hilo: got %h want 0", nm, hilo_o); end
      vectors++; if (stallreq !== 1'b0) begin miscompares++; $display("FAIL %s_stallreq: got %b want 0", nm, stallreq); end
      vectors++; if (div_start !== 1'b0) begin miscompares++; $display("FAIL %s_start: got %b want 0", nm, div_start); end
      next_cycle();
      #1;
      vectors++; if ({div_start, hilo_valid} !== 2'b00) begin miscompares++; $display("FAIL %s_after: got %b want 00", nm, {div_start, hilo_valid}); end
      return;
    end
    vectors++; if (div_start !== 1'b1) begin miscompares++; $display("FAIL %s_start: got %b want 1", nm, div_start); end
    vectors++; if ({div_signed, div_op1, div_op2} !== {s, a, b}) begin miscompares++; $display("FAIL %s_operands: got %h want %h", nm, {div_signed, div_op1, div_op2}, {s, a, b}); end
    stalls = 2;
    guard = 0;
    while (!div_ready && guard < 200) begin
      next_cycle();
      #1;
      guard++;
      if (stallreq) stalls++;
    end
    vectors++; if (div_ready !== 1'b1) begin miscompares++; $display("FAIL %s_ready_timeout: got %b want 1", nm, div_ready); end
    next_cycle();
    #1;
    vectors++; if (hilo_valid !== 1'b1) begin miscompares++; $display("FAIL %s_valid: got %b want 1", nm, hilo_valid); end
    vectors++; if (hilo_o !== exp) begin miscompares++; $display("FAIL %s_hilo: got %h want %h", nm, hilo_o, exp); end
    vectors++; if ({stallreq, div_start} !== 2'b00) begin miscompares++; $display("FAIL %s_done_ctrl: got %b want 00", nm, {stallreq, div_start}); end
    vectors++; if (stalls != int'(lat) + 2) begin miscompares++; $display("FAIL %s_stall_cycles: got %0d want %0d", nm, stalls, lat + 2); end
    next_cycle();
    #1;
    vectors++; if (hilo_valid !== 1'b0) begin miscompares++; $display("FAIL %s_after: got %b want 0", nm, hilo_valid); end
  endtask

  task automatic test_madd();
    run_mac(OP_MADD, 64'h0000_0001_FFFF_FFFF, 64'h1, 64'h0000_0001_FFFF_FFFF, "madd");
  endtask

  task automatic test_msub_wrap();
    run_mac(OP_MSUB, 64'h0, 64'h1, 64'h0, "msub_wrap");
  endtask

  task automatic test_mac_random();
    logic [2:0] o;
    logic [63:0] h0;
    for (int i = 0; i < 16; i++) begin
      o = 3'(OP_MADD + $urandom_range(0, 3));
      h0 = {$urandom, $urandom};
      run_mac(o, h0, {$urandom, $urandom}, ($urandom_range(0, 1) != 0) ? h0 : {$urandom, $urandom}, "mac_rand");
    end
  endtask

  task automatic test_div();
    run_div(32'd100, 32'd7, 1'b1, 34, "div_100_7");
  endtask

  task automatic test_div_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 1) != 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
      if (b == '0 || b == '1) b = 32'd3;
      run_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(1, 8), "div_rand");
    end
  endtask

  task automatic test_div_zero();
    run_div(32'd123, 32'd0, 1'b1, 5, "div_zero");
    run_div(32'd77, 32'd0, 1'b0, 5, "divu_zero");
  endtask

  task automatic test_mem_stall();
    logic [63:0] m;
    logic [63:0] exp;
    m = {$urandom, $urandom};
    next_cycle();
    op = OP_MADD; op_valid = 1'b1; hilo_i = {$urandom, $urandom}; mul_result = m;
    next_cycle();
    op = OP_NOP; op_valid = 1'b0; stall_ext = 6'b011111;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall_ext = 6'b000000;
      hilo_i = {$urandom, $urandom};
      #1;
      exp = hilo_i + m;
      vectors++; if (hilo_valid !== 1'b1) begin miscompares++; $display("FAIL mem_stall_valid[%0d]: got %b want 1", i, hilo_valid); end
      vectors++; if (hilo_o !== exp) begin miscompares++; $display("FAIL mem_stall_hilo[%0d]: got %h want %h", i, hilo_o, exp); end
      next_cycle();
    end
    #1;
    vectors++; if ({hilo_valid, stallreq} !== 2'b00) begin miscompares++; $display("FAIL mem_stall_release: got %b want 00", {hilo_valid, stallreq}); end
  endtask

  task automatic test_flush_div();
    int guard;
    div_lat = 5;
    next_cycle();
    op = OP_DIVU; op_valid = 1'b1; opdata1 = 32'd1000; opdata2 = 32'd9;
    next_cycle();
    op = OP_NOP; op_valid = 1'b0;
    guard = 0;
    while (!div_ready && guard < 50) begin
      next_cycle();
      guard++;
    end
    vectors++; if (div_ready !== 1'b1) begin miscompares++; $display("FAIL flush_div_ready_timeout: got %b want 1", div_ready); end
    flush = 1'b1;
    #1;
    vectors++; if (div_annul !== 1'b1) begin miscompares++; $display("FAIL flush_div_annul: got %b want 1", div_annul); end
    vectors++; if ({hilo_valid, stallreq} !== 2'b00) begin miscompares++; $display("FAIL flush_div_out: got %b want 00", {hilo_valid, stallreq}); end
    next_cycle();
    flush = 1'b0;
    #1;
    vectors++; if ({div_start, div_annul, hilo_valid, stallreq} !== 4'b0000) begin miscompares++; $display("FAIL flush_div_idle: got %b want 0000", {div_start, div_annul, hilo_valid, stallreq}); end
    next_cycle();
    #1;
    vectors++; if (hilo_valid !== 1'b0) begin miscompares++; $display("FAIL flush_div_discard: got %b want 0", hilo_valid); end
  endtask

  task automatic test_flush_mac();
    next_cycle();
    op = OP_MSUBU; op_valid = 1'b1; hilo_i = {$urandom, $urandom}; mul_result = {$urandom, $urandom};
    next_cycle();
    op = OP_NOP; op_valid = 1'b0; flush = 1'b1;
    #1;
    vectors++; if ({hilo_valid, stallreq, div_annul} !== 3'b000) begin miscompares++; $display("FAIL flush_mac: got %b want 000", {hilo_valid, stallreq, div_annul}); end
    next_cycle();
    flush = 1'b0;
    #1;
    vectors++; if (hilo_valid !== 1'b0) begin miscompares++; $display("FAIL flush_mac_after: got %b want 0", hilo_valid); end
    run_mac(OP_MADDU, 64'h10, 64'h5, 64'h10, "post_flush");
  endtask

  task automatic test_back_to_back();
    logic [63:0] h;
    logic [63:0] m1;
    logic [63:0] m2;
    h = {$urandom, $urandom}; m1 = {$urandom, $urandom}; m2 = {$urandom, $urandom};
    next_cycle();
    op = OP_MADDU; op_valid = 1'b1; hilo_i = h; mul_result = m1;
    next_cycle();
    op = OP_MSUB; mul_result = m2;
    #1;
    vectors++; if (stallreq !== 1'b0) begin miscompares++; $display("FAIL b2b_ignore_op: got %b want 0", stallreq); end
    vectors++; if (hilo_o !== h + m1) begin miscompares++; $display("FAIL b2b_first: got %h want %h", hilo_o, h + m1); end
    next_cycle();
    #1;
    vectors++; if ({stallreq, hilo_valid} !== 2'b10) begin miscompares++; $display("FAIL b2b_second_issue: got %b want 10", {stallreq, hilo_valid}); end
    next_cycle();
    op = OP_NOP; op_valid = 1'b0;
    #1;
    vectors++; if (hilo_o !== h - m2) begin miscompares++; $display("FAIL b2b_second: got %h want %h", hilo_o, h - m2); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    div_lat = 30;
    next_cycle();
    op = OP_DIV; op_valid = 1'b1; opdata1 = 32'd50; opdata2 = 32'd3;
    next_cycle();
    op = OP_NOP; op_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    vectors++; if ({div_start, div_annul, stallreq, hilo_valid} !== 4'b0000) begin miscompares++; $display("FAIL reset_mid: got %b want 0000", {div_start, div_annul, stallreq, hilo_valid}); end
    next_cycle();
    rst = 1'b0;
    run_div(32'd9, 32'd2, 1'b0, 3, "post_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_madd();
    test_msub_wrap();
    test_mac_random();
    test_div();
    test_div_zero();
    test_div_random();
    test_mem_stall();
    test_flush_div();
    test_flush_mac();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_multicycle_ctrl.md
# ex_multicycle_ctrl

Sequencer for the multi-cycle HI/LO operations in the EX stage: two-cycle multiply-accumulate (MADD/MADDU/MSUB/MSUBU) and the handshake with the iterative divider (DIV/DIVU). It holds the intermediate product and divider operands in its own registers. It raises the EX stall request while an operation is in flight, and presents the final 64-bit HI/LO value to EX for the normal ex_hi/ex_lo/ex_whilo path into the EX/MEM register.

## Interface
Parameters:
- DATA_W, 32, width of one register; HI/LO and product are 2*DATA_W.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- op  in  3  multi-cycle opcode (package encoding: NOP, MADD, MADDU, MSUB, MSUBU, DIV, DIVU).
- op_valid  in  1  EX holds a valid multi-cycle instruction.
- flush  in  1  annul the in-flight operation (exception).
- stall  in  6  pipeline stall vector; stall[3]=EX held, stall[4]=MEM held.
- mul_result  in  2*DATA_W  product from the EX multiplier, already signed/unsigned per op.
- hilo_i  in  2*DATA_W  current {HI,LO} after forwarding.
- opdata1, opdata2  in  DATA_W  dividend, divisor.
- div_result  in  2*DATA_W  divider result {remainder,quotient}.
- div_ready  in  1  divider result valid (one-cycle pulse).
- div_start  out  1  divider start, held until ready.
- div_signed  out  1  1 for DIV.
- div_annul  out  1  one-cycle divider abort.
- div_op1, div_op2  out  DATA_W  latched operands.
- stallreq  out  1  EX stall request to the stall controller.
- hilo_o  out  2*DATA_W  final {HI,LO}.
- hilo_valid  out  1  hilo_o is valid this cycle; EX asserts whilo.

## Operation
- Reset: state IDLE; all outputs and internal registers 0.
- States: IDLE, MAC_ACC, DIV_WAIT, DONE.
- IDLE with op_valid, MAC op and !flush:
  - latch mul_result into prod_r;
  - stallreq=1 (combinational);
  - go to MAC_ACC.
  - Starting does not depend on stall[3], because stall[3] is caused by this block's own stallreq.
- MAC_ACC:
  - MADD/MADDU: hilo_o = hilo_i + prod_r; MSUB/MSUBU: hilo_o = hilo_i - prod_r; both modulo 2^(2*DATA_W), no carry-out.
  - hilo_valid=1, stallreq=0.
  - Stay in MAC_ACC while stall[3]=Stop, recomputing from hilo_i each cycle; go to IDLE when stall[3]=NoStop.
- IDLE with op_valid, DIV op and !flush:
  - stallreq=1.
  - opdata2 != 0: latch operands and div_signed; go to DIV_WAIT.
  - opdata2 == 0: latch result 0; go to DONE (one stall cycle, divider untouched).
- DIV_WAIT:
  - div_start=1, stallreq=1.
  - On div_ready: latch div_result into res_r; go to DONE.
- DONE:
  - hilo_o=res_r, hilo_valid=1, stallreq=0, div_start=0.
  - Hold while stall[3]=Stop; go to IDLE otherwise.
- op_valid is ignored outside IDLE: the same instruction is still in EX.
- flush, in any state:
  - next state is IDLE; prod_r and res_r are cleared.
  - hilo_valid and stallreq are forced 0 in the flush cycle.
  - If the state is DIV_WAIT, div_annul=1 in that cycle and div_start=0 from the next cycle.
  - flush and div_ready in the same cycle: flush wins; the result is discarded.
- An async reset mid-operation returns the block to IDLE; the divider is not annulled. The divider shares rst.

## Timing
- div_start, div_op1, div_op2 and div_signed are registered. hilo_o, hilo_valid, stallreq and div_annul are combinational from the state, the registers and the inputs.
- MAC latency, with C = the issue cycle:
  - cycle C: stallreq=1;
  - C+1: hilo_valid=1;
  - exactly one stall cycle if MEM is not stalled.
- DIV latency:
  - C: stallreq=1, state moves to DIV_WAIT;
  - C+1: div_start first high;
  - div_ready in cycle k: hilo_valid=1 at k+1;
  - stall cycles = k+1-C.
- Divide by zero: hilo_valid=1 at C+1, hilo_o=0.
- No back-to-back starts: the earliest new operation starts in the cycle after leaving MAC_ACC or DONE.

## Structure
- Shared package (alongside the existing define include) holds:
  - the op encodings;
  - the state encoding;
  - the Stop/NoStop and ResetEnable constants;
  - DoubleRegisterBus width.
- Single module, no sub-module. The add/sub is one expression selected by an op-latched sub flag.
- The divider remains a separate existing module.

## Test plan
- MADD: hilo_i=0x0000_0001_FFFF_FFFF, mul_result=1 -> C stallreq=1; C+1 hilo_valid=1, hilo_o=0x0000_0002_0000_0000.
- MSUB wrap: hilo_i=0, mul_result=1 -> hilo_o=0xFFFF_FFFF_FFFF_FFFF at C+1.
- DIV: opdata1=100, opdata2=7, divider model returns ready after 34 cycles -> div_start high C+1 until ready; hilo_o={2,14} one cycle after ready; stallreq low exactly then.
- Divide by zero: opdata2=0 -> div_start never rises; C+1 hilo_valid=1, hilo_o=0.
- MEM stall in MAC_ACC: stall=6'b011111 for 3 cycles -> hilo_valid held 3 cycles, state MAC_ACC, then IDLE.
- Flush in DIV_WAIT coincident with div_ready -> div_annul=1 that cycle, hilo_valid=0, next cycle IDLE with div_start=0.
